wb_stage: RTL and testbench

Writeback stage of the RISC-V pipeline and the writer-side counterpart of the ID-stage register file: it accepts retiring instructions from the MEM stage, waits for load data where required, and drives the register file write port. It selects the result source (ALU, load data, PC+4), performs load byte/halfword extraction with sign/zero extension, and suppresses writes to x0. It emits a one-cycle retire pulse per completed instruction.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_stage_load_align.sv | 45 ++++
 rtl/wb_stage.sv | 141 ++++++++++++++
 tb/tb_wb_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and the load alignment logic.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_ZERO = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: picks a byte/half/word from an aligned read word
// and sign- or zero-extends it according to funct3.
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    // Halfword loads look only at offset[1]; a misaligned offset[0] is ignored.
    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    // Reserved encodings fall through to a full-word load.
    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            F3_LW:   data = word;
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from MEM, waits for load data when needed,
// and drives the register file write port with a one-cycle retire pulse.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      in_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_i,
    input  logic [1:0]                in_wb_sel_i,
    input  logic [DATA_WIDTH-1:0]     in_alu_result_i,
    input  logic [DATA_WIDTH-1:0]     in_pc_plus4_i,
    input  logic [2:0]                in_funct3_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      rf_write_en_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_w_o,
    output logic [DATA_WIDTH-1:0]     rf_data_w_o,
    output logic                      retire_o,
    output logic                      busy_o
);

    state_e state, state_next;
    wb_sel_e in_wb_sel;

    logic                      accept;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      reg_write_q;
    logic [2:0]                funct3_q;
    logic [1:0]                offset_q;

    logic [DATA_WIDTH-1:0]     sel_result;
    logic [DATA_WIDTH-1:0]     load_data;

    logic                      fire;
    logic                      fire_reg_write;
    logic [REG_ADDR_WIDTH-1:0] fire_rd;
    logic [DATA_WIDTH-1:0]     fire_data;
    logic                      fire_we;

    assign in_wb_sel  = wb_sel_e'(in_wb_sel_i);
    assign in_ready_o = (state == S_IDLE);
    assign busy_o     = (state == S_WAIT_MEM);
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        sel_result = '0;
        case (in_wb_sel)
            WB_ALU:  sel_result = in_alu_result_i;
            WB_PC4:  sel_result = in_pc_plus4_i;
            default: sel_result = '0;
        endcase
    end

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .funct3 (funct3_q),
        .offset (offset_q),
        .word   (mem_rdata_i),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the write that completes this cycle (non-load on accept,
    // load on its read response).
    always_comb begin
        state_next     = state;
        fire           = 1'b0;
        fire_reg_write = 1'b0;
        fire_rd        = '0;
        fire_data      = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_wb_sel == WB_MEM) begin
                        state_next = S_WAIT_MEM;
                    end else begin
                        fire           = 1'b1;
                        fire_reg_write = in_reg_write_i;
                        fire_rd        = in_rd_i;
                        fire_data      = sel_result;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (mem_rvalid_i) begin
                    state_next     = S_IDLE;
                    fire           = 1'b1;
                    fire_reg_write = reg_write_q;
                    fire_rd        = rd_q;
                    fire_data      = load_data;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign fire_we = fire & fire_reg_write & (fire_rd != '0);

    // NOTE: these capture registers carry no reset; they are only read in
    // WAIT_MEM, which is always entered through an accept that loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q        <= in_rd_i;
            reg_write_q <= in_reg_write_i;
            funct3_q    <= in_funct3_i;
            offset_q    <= in_alu_result_i[1:0];
        end
    end

    // Address and data only move on a real write, so they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_en_o <= 1'b0;
            retire_o      <= 1'b0;
            rf_addr_w_o   <= '0;
            rf_data_w_o   <= '0;
        end else begin
            rf_write_en_o <= fire_we;
            retire_o      <= fire;
            if (fire_we) begin
                rf_addr_w_o <= fire_rd;
                rf_data_w_o <= fire_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: transaction-level model compared every cycle,
// plus directed literal expectations from hand-computed vectors.
module tb_wb_stage;
    import wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_reg_write_i;
    logic [4:0]  in_rd_i;
    logic [1:0]  in_wb_sel_i;
    logic [31:0] in_alu_result_i;
    logic [31:0] in_pc_plus4_i;
    logic [2:0]  in_funct3_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rf_write_en_o;
    logic [4:0]  rf_addr_w_o;
    logic [31:0] rf_data_w_o;
    logic        retire_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    wb_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_reg_write_i  (in_reg_write_i),
        .in_rd_i         (in_rd_i),
        .in_wb_sel_i     (in_wb_sel_i),
        .in_alu_result_i (in_alu_result_i),
        .in_pc_plus4_i   (in_pc_plus4_i),
        .in_funct3_i     (in_funct3_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .rf_write_en_o   (rf_write_en_o),
        .rf_addr_w_o     (rf_addr_w_o),
        .rf_data_w_o     (rf_data_w_o),
        .retire_o        (retire_o),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend;
    bit          m_rw;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    bit          m_we, m_retire;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_result(logic [1:0] sel, logic [31:0] alu, logic [31:0] pc4);
        if (sel == 2'd0) return alu;
        if (sel == 2'd2) return pc4;
        return 32'd0;
    endfunction

    task automatic m_retire_instr(input bit rw, input logic [4:0] rd, input logic [31:0] val);
        m_retire = 1;
        if (rw && rd != 5'd0) begin
            m_we   = 1;
            m_addr = rd;
            m_data = val;
        end
    endtask

    always @(posedge clk) begin
        m_we     = 0;
        m_retire = 0;
        if (rst) begin
            m_pend = 0;
            m_addr = '0;
            m_data = '0;
        end else if (!m_pend) begin
            if (in_valid_i) begin
                if (in_wb_sel_i == 2'd1) begin
                    m_pend = 1;
                    m_rw   = in_reg_write_i;
                    m_rd   = in_rd_i;
                    m_f3   = in_funct3_i;
                    m_off  = in_alu_result_i[1:0];
                end else begin
                    m_retire_instr(in_reg_write_i, in_rd_i,
                                   m_result(in_wb_sel_i, in_alu_result_i, in_pc_plus4_i));
                end
            end
        end else if (mem_rvalid_i) begin
            m_pend = 0;
            m_retire_instr(m_rw, m_rd, m_load(m_f3, m_off, mem_rdata_i));
        end
        cmp_en = 1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model retire", 32'(retire_o), 32'(m_retire));
            check("model we", 32'(rf_write_en_o), 32'(m_we));
            check("model addr", 32'(rf_addr_w_o), 32'(m_addr));
            check("model data", rf_data_w_o, m_data);
            check("model busy", 32'(busy_o), 32'(m_pend));
            check("model ready", 32'(in_ready_o), 32'(!m_pend));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
        in_valid_i      = 1'b1;
        in_reg_write_i  = rw;
        in_rd_i         = rd;
        in_wb_sel_i     = sel;
        in_alu_result_i = alu;
        in_pc_plus4_i   = pc4;
        in_funct3_i     = f3;
    endtask

    task automatic send(input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] pc4);
        set_in(rw, rd, sel, alu, pc4, 3'd0);
        step();
        in_valid_i = 1'b0;
    endtask

    // Load with response `delay` cycles after accept; a competing ALU op is held
    // valid during the wait and must not be accepted.
    task automatic load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdata, input int delay,
                        input bit early_rvalid, input logic [31:0] exp);
        set_in(1'b1, rd, WB_MEM, alu, 32'h0, f3);
        mem_rvalid_i = early_rvalid;
        mem_rdata_i  = 32'hFFFF_FFFF;
        step();
        mem_rvalid_i = 1'b0;
        set_in(1'b1, 5'd9, WB_ALU, 32'hDEAD, 32'h0, 3'd0);
        for (int i = 0; i < delay - 1; i++) begin
            @(negedge clk);
            check({name, " busy"}, 32'(busy_o), 32'd1);
            check({name, " ready"}, 32'(in_ready_o), 32'd0);
            check({name, " no retire"}, 32'(retire_o), 32'd0);
            step();
        end
        in_valid_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        @(negedge clk);
        check({name, " busy last"}, 32'(busy_o), 32'd1);
        step();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        check({name, " data"}, rf_data_w_o, exp);
        check({name, " addr"}, 32'(rf_addr_w_o), 32'(rd));
        check({name, " we"}, 32'(rf_write_en_o), 32'd1);
        check({name, " retire"}, 32'(retire_o), 32'd1);
        check({name, " ready after"}, 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        in_valid_i      = 1'b0;
        in_reg_write_i  = 1'b0;
        in_rd_i         = '0;
        in_wb_sel_i     = '0;
        in_alu_result_i = '0;
        in_pc_plus4_i   = '0;
        in_funct3_i     = '0;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = '0;
        step();
        step();
        rst = 1'b0;

        @(negedge clk);
        check("reset we", 32'(rf_write_en_o), 32'd0);
        check("reset addr", 32'(rf_addr_w_o), 32'd0);
        check("reset data", rf_data_w_o, 32'd0);
        check("reset retire", 32'(retire_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset ready", 32'(in_ready_o), 32'd1);

        send(1'b1, 5'd5, WB_ALU, 32'h1234, 32'h0);
        @(negedge clk);
        check("alu we", 32'(rf_write_en_o), 32'd1);
        check("alu addr", 32'(rf_addr_w_o), 32'd5);
        check("alu data", rf_data_w_o, 32'h1234);
        check("alu retire", 32'(retire_o), 32'd1);

        send(1'b1, 5'd0, WB_ALU, 32'hFFFF, 32'h0);
        @(negedge clk);
        check("x0 we", 32'(rf_write_en_o), 32'd0);
        check("x0 retire", 32'(retire_o), 32'd1);
        check("x0 data held", rf_data_w_o, 32'h1234);
        step();
        @(negedge clk);
        check("retire one cycle", 32'(retire_o), 32'd0);

        load("lb",  5'd7,  3'b000, 32'h0000_0102, 32'h0080_0000, 3, 1'b0, 32'hFFFF_FF80);
        load("lbu", 5'd8,  3'b100, 32'h0000_0102, 32'h0080_0000, 3, 1'b1, 32'h0000_0080);
        load("lh",  5'd10, 3'b001, 32'h0000_0002, 32'h8001_0000, 1, 1'b0, 32'hFFFF_8001);
        load("lhu", 5'd11, 3'b101, 32'h0000_0003, 32'h8001_0000, 2, 1'b0, 32'h0000_8001);
        load("lw",  5'd12, 3'b010, 32'h0000_0001, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D);
        load("rsv", 5'd13, 3'b111, 32'h0000_0002, 32'h1234_5678, 2, 1'b0, 32'h1234_5678);

        // Back-to-back accepts: ALU, PC+4, ZERO, ALU without write, ALU.
        for (int i = 0; i < 5; i++) begin
            logic [1:0] sel;
            sel = (i == 1) ? WB_PC4 : (i == 2) ? WB_ZERO : WB_ALU;
            set_in(i != 3, 5'(i + 1), sel, 32'h100 * (i + 1), 32'h2000, 3'd0);
            check("b2b ready", 32'(in_ready_o), 32'd1);
            step();
        end
        in_valid_i = 1'b0;
        @(negedge clk);
        check("b2b last data", rf_data_w_o, 32'h500);
        check("b2b last addr", 32'(rf_addr_w_o), 32'd5);

        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        step();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        check("stray rvalid we", 32'(rf_write_en_o), 32'd0);
        check("stray rvalid retire", 32'(retire_o), 32'd0);

        set_in(1'b1, 5'd20, WB_MEM, 32'h0, 32'h0, 3'b010);
        step();
        in_valid_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst          = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h7777_7777;
        step();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        check("rst wait we", 32'(rf_write_en_o), 32'd0);
        check("rst wait retire", 32'(retire_o), 32'd0);
        check("rst wait addr", 32'(rf_addr_w_o), 32'd0);
        check("rst wait data", rf_data_w_o, 32'd0);
        check("rst wait ready", 32'(in_ready_o), 32'd1);
        check("rst wait busy", 32'(busy_o), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
